mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 28 ++
 rtl/mem_ctrl_load_ext.sv | 21 ++
 rtl/mem_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: access sizes,
// controller states and the access-size to byte-count mapping.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MEM_NOP  = 2'b00,
        MEM_BYTE = 2'b01,
        MEM_HALF = 2'b10,
        MEM_WORD = 2'b11
    } mem_sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } state_e;

    // Number of bytes moved for a given access size.
    function automatic logic [2:0] sel_bytes(input logic [1:0] sel);
        case (sel)
            MEM_BYTE: sel_bytes = 3'd1;
            MEM_HALF: sel_bytes = 3'd2;
            default:  sel_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_load_ext.sv
// Load data sign/zero extension for byte, halfword and word loads.
module load_ext
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  sel,
    input  logic        sgn,
    output logic [31:0] ext
);

    // Replicate the top bit of the loaded quantity, or zero-fill.
    always_comb begin
        ext = raw;
        case (sel)
            MEM_BYTE: ext = sgn ? {{24{raw[7]}}, raw[7:0]}   : {24'h0, raw[7:0]};
            MEM_HALF: ext = sgn ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
            default:  ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: turns MEM-stage load/store requests into
// little-endian byte accesses on an 8-bit RAM with one-cycle read latency.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_sel,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din
);

    state_e      state, state_nx;
    logic        we_q;
    logic [1:0]  sel_q;
    logic        sgn_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] buf_q;
    logic [31:0] merged;
    logic [31:0] ext_data;
    logic [31:0] resp_data_q;
    logic [2:0]  idx;
    logic [2:0]  cnt;
    logic        accept;
    logic        last;
    logic [1:0]  lane_prev;
    logic [1:0]  lane_last;

    assign accept    = (state == IDLE) && req_valid && (req_sel != MEM_NOP);
    assign last      = (idx == cnt - 3'd1);
    assign lane_prev = 2'(idx - 3'd1);
    assign lane_last = 2'(cnt - 3'd1);
    assign resp_data = resp_data_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state and RAM/handshake outputs; RAM bus is idle-zero outside XFER.
    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        ram_a      = '0;
        ram_wr     = 1'b0;
        ram_dout   = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) state_nx = XFER;
            end
            XFER: begin
                ram_a    = addr_q + {29'b0, idx};
                ram_wr   = we_q;
                ram_dout = we_q ? wdata_q[{idx[1:0], 3'b000} +: 8] : '0;
                if (last) state_nx = we_q ? DONE : WAIT;
            end
            WAIT: state_nx = DONE;
            DONE: begin
                resp_valid = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Buffer with the final read byte folded in, so the extended word can be
    // registered on the WAIT->DONE edge and be visible during DONE.
    always_comb begin
        merged = buf_q;
        merged[{lane_last, 3'b000} +: 8] = ram_din;
    end

    load_ext u_load_ext (
        .raw (merged),
        .sel (sel_q),
        .sgn (sgn_q),
        .ext (ext_data)
    );

    // Request latch, byte index and read-data assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q        <= 1'b0;
            sel_q       <= '0;
            sgn_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            idx         <= '0;
            cnt         <= '0;
            buf_q       <= '0;
            resp_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        sel_q   <= req_sel;
                        sgn_q   <= req_signed;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        idx     <= '0;
                        cnt     <= sel_bytes(req_sel);
                    end
                end
                XFER: begin
                    idx <= idx + 3'd1;
                    if (!we_q && idx != 3'd0)
                        buf_q[{lane_prev, 3'b000} +: 8] <= ram_din;
                end
                WAIT: begin
                    buf_q       <= merged;
                    resp_data_q <= ext_data;
                end
                default: ;
            endcase
        end
    end

endmodule
